hazard_detection_unit: RTL

- Consumes the outputs of the ID/EX pipeline register, together with the source-register addresses of the instruction currently in ID.
- Generates the stall and flush controls that the PC, IF/ID and ID/EX registers need for load-use hazards and taken branches/jumps.
- Holds a small FSM for multi-cycle load stalls, plus saturating stall/flush event counters.
- Sits beside the decode stage in the 5-stage DLX pipeline.

---
 rtl/dlx_hazard_pkg.sv | 6 +
 rtl/hazard_detection_unit_if.sv | 21 ++
 rtl/sat_counter.sv | 17 +
 rtl/hazard_detection_unit.sv | 66 ++++++
 4 files changed

// File: rtl/dlx_hazard_pkg.sv
// dlx_hazard_pkg: shared state encoding and constants for the DLX hazard unit
package dlx_hazard_pkg;
  typedef enum logic {HZ_IDLE, HZ_LOAD_STALL} hz_state_e;
  localparam int REG_ZERO = 0;
  localparam int STALL_W = 4;
endpackage

// File: rtl/hazard_detection_unit_if.sv
// hazard_detection_unit_if: ID/EX hazard inputs and pipeline stall/flush controls
interface hazard_detection_unit_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH = 16
) ();
  logic [REG_ADDR_WIDTH-1:0] id_read_address1, id_read_address2, ex_reg_wr_addr;
  logic id_uses_rs1, id_uses_rs2, ex_reg_wr_en, ex_mem_data_rd_en;
  logic ex_branch_taken, ex_jump_taken, cnt_clr;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_flush, hazard_busy;
  logic [CNT_WIDTH-1:0] stall_count, flush_count;
  modport master (
    output id_read_address1, id_read_address2, ex_reg_wr_addr, id_uses_rs1, id_uses_rs2,
           ex_reg_wr_en, ex_mem_data_rd_en, ex_branch_taken, ex_jump_taken, cnt_clr,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, hazard_busy, stall_count, flush_count
  );
  modport slave (
    input  id_read_address1, id_read_address2, ex_reg_wr_addr, id_uses_rs1, id_uses_rs2,
           ex_reg_wr_en, ex_mem_data_rd_en, ex_branch_taken, ex_jump_taken, cnt_clr,
    output pc_stall, if_id_stall, if_id_flush, id_ex_flush, hazard_busy, stall_count, flush_count
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that saturates at all-ones, clear wins over increment
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;
  always_comb count_d = clr ? '0 : (inc && !(&count_q)) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: load-use stall and branch/jump flush control for the DLX decode stage
module hazard_detection_unit
  import dlx_hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_detection_unit_if.slave hz
);
  hz_state_e state_q, state_d;
  logic [STALL_W-1:0] rem_q, rem_d;
  logic load_hazard, redirect, stall, flush, busy, inc_stall, inc_flush;
  assign load_hazard = hz.ex_mem_data_rd_en && hz.ex_reg_wr_en &&
                       (hz.ex_reg_wr_addr != REG_ADDR_WIDTH'(REG_ZERO)) &&
                       ((hz.id_uses_rs1 && hz.id_read_address1 == hz.ex_reg_wr_addr) ||
                        (hz.id_uses_rs2 && hz.id_read_address2 == hz.ex_reg_wr_addr));
  assign redirect = hz.ex_branch_taken || hz.ex_jump_taken;
  assign busy = state_q == HZ_LOAD_STALL;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    stall = 1'b0;
    flush = 1'b0;
    inc_stall = 1'b0;
    inc_flush = 1'b0;
    if (redirect) begin
      flush = 1'b1;
      inc_flush = 1'b1;
      state_d = HZ_IDLE;
      rem_d = '0;
    end else if (busy) begin
      // EX only holds bubbles here, so the hazard is not re-checked
      stall = 1'b1;
      rem_d = rem_q - 1'b1;
      state_d = (rem_q <= STALL_W'(1)) ? HZ_IDLE : HZ_LOAD_STALL;
    end else if (load_hazard) begin
      stall = 1'b1;
      inc_stall = 1'b1;
      rem_d = STALL_W'(LOAD_STALL_CYCLES - 1);
      state_d = (LOAD_STALL_CYCLES > 1) ? HZ_LOAD_STALL : HZ_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= HZ_IDLE;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
    end
  // controls are forced low while the surrounding pipe is held in reset
  assign hz.pc_stall = rst_n && stall;
  assign hz.if_id_stall = rst_n && stall;
  assign hz.if_id_flush = rst_n && flush;
  assign hz.id_ex_flush = rst_n && (stall || flush);
  assign hz.hazard_busy = rst_n && busy;
  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .clr(hz.cnt_clr), .inc(inc_stall), .count(hz.stall_count)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .clr(hz.cnt_clr), .inc(inc_flush), .count(hz.flush_count)
  );
endmodule
